// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

   typedef enum logic {PLAY, GAME_OVER} state_t;

   localparam int BCD_W = 4;

   // Elaboration-time helper: binary value to packed BCD, units digit in the low nibble.
   function automatic logic [4*BCD_W-1:0] to_bcd(int value, int digits);
      logic [4*BCD_W-1:0] res;
      int rem;
      res = '0;
      rem = value;
      for (int i = 0; i < 4; i++) begin
         if (i < digits) begin
            res[i*BCD_W +: BCD_W] = 4'(rem % 10);
            rem = rem / 10;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// One player's saturating BCD score; updates 1 cycle after inc, clr wins over inc.
// nxt exposes the post-increment value so the parent can compare before the edge.
module bcd_counter
   import score_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      inc,
   output logic [DIGITS*BCD_W-1:0]   bcd,
   output logic [DIGITS*BCD_W-1:0]   nxt,
   output logic                      at_max
);

   logic carry;

   always_comb begin
      at_max = 1'b1;
      nxt    = bcd;
      carry  = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[d*BCD_W +: BCD_W] != 4'd9)
            at_max = 1'b0;
         if (carry) begin
            if (bcd[d*BCD_W +: BCD_W] == 4'd9) begin
               nxt[d*BCD_W +: BCD_W] = 4'd0;
            end else begin
               nxt[d*BCD_W +: BCD_W] = bcd[d*BCD_W +: BCD_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      // All nines would wrap to zero; hold instead.
      if (at_max)
         nxt = bcd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bcd <= '0;
      else if (clr)
         bcd <= '0;
      else if (inc)
         bcd <= nxt;
   end

endmodule

// File: rtl/score_keeper.sv
// Multi-player BCD score keeper with edge-detected point requests and win detection.
// Latency 1 cycle, all outputs registered; no backpressure, a win freezes scoring until clear.
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int DIGITS      = 2,
   parameter int WIN_SCORE   = 11,
   localparam int WID        = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clear,
   input  logic [NUM_PLAYERS-1:0]               score_in,
   output logic [NUM_PLAYERS*DIGITS*BCD_W-1:0]  score_bcd,
   output logic [NUM_PLAYERS-1:0]               point_strobe,
   output logic                                 game_over,
   output logic [WID-1:0]                       winner_id
);

   localparam logic [4*BCD_W-1:0]      WIN_BCD_FULL = to_bcd(WIN_SCORE, DIGITS);
   localparam logic [DIGITS*BCD_W-1:0] WIN_BCD      = WIN_BCD_FULL[DIGITS*BCD_W-1:0];

   state_t                                   state;
   logic [NUM_PLAYERS-1:0]                   score_prev;
   logic [NUM_PLAYERS-1:0]                   accept;
   logic [NUM_PLAYERS-1:0]                   win_hit;
   logic [NUM_PLAYERS-1:0]                   at_max;
   logic [NUM_PLAYERS-1:0][DIGITS*BCD_W-1:0] nxt_bus;
   logic [WID-1:0]                           win_idx;

   assign accept = score_in & ~score_prev & {NUM_PLAYERS{(state == PLAY) && !clear}};

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      bcd_counter #(.DIGITS(DIGITS)) u_cnt (
         .clk    (clk),
         .reset  (reset),
         .clr    (clear),
         .inc    (accept[p]),
         .bcd    (score_bcd[p*DIGITS*BCD_W +: DIGITS*BCD_W]),
         .nxt    (nxt_bus[p]),
         .at_max (at_max[p])
      );
   end

   // A saturated counter produces no new value, so it cannot newly reach the target.
   always_comb begin
      win_hit = '0;
      win_idx = '0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         win_hit[p] = (WIN_SCORE != 0) && accept[p] && !at_max[p] && (nxt_bus[p] == WIN_BCD);
      for (int p = NUM_PLAYERS - 1; p >= 0; p--)
         if (win_hit[p])
            win_idx = WID'(p);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= PLAY;
         score_prev   <= '0;
         point_strobe <= '0;
         game_over    <= 1'b0;
         winner_id    <= '0;
      end else begin
         score_prev   <= score_in;
         point_strobe <= accept;
         if (clear) begin
            state     <= PLAY;
            game_over <= 1'b0;
            winner_id <= '0;
         end else if ((state == PLAY) && (|win_hit)) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            winner_id <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench: a WIN_SCORE=11 instance for scoring/win/clear/reset, a free-play instance for carry and saturation.
module tb_score_keeper;

   typedef struct packed {
      logic [1:0]  si;
      logic        cl;
      logic [15:0] bcd;
      logic [1:0]  st;
      logic        go;
      logic        win;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear, clear_f;
   logic [1:0]  score_in, score_in_f;
   logic [15:0] score_bcd, score_bcd_f;
   logic [1:0]  point_strobe, point_strobe_f;
   logic        game_over, game_over_f;
   logic [0:0]  winner_id, winner_id_f;

   int checks   = 0;
   int failures = 0;
   vec_t tbl [0:15];

   always #5 clk = ~clk;

   score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11)) dut (
      .clk(clk), .reset(reset), .clear(clear), .score_in(score_in),
      .score_bcd(score_bcd), .point_strobe(point_strobe),
      .game_over(game_over), .winner_id(winner_id)
   );

   score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0)) dut_f (
      .clk(clk), .reset(reset), .clear(clear_f), .score_in(score_in_f),
      .score_bcd(score_bcd_f), .point_strobe(point_strobe_f),
      .game_over(game_over_f), .winner_id(winner_id_f)
   );

   function automatic vec_t mk(logic [1:0] si, logic cl, logic [15:0] bcd,
                               logic [1:0] st, logic go, logic win);
      vec_t v;
      v.si = si; v.cl = cl; v.bcd = bcd; v.st = st; v.go = go; v.win = win;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after a posedge; outputs are sampled 1 unit after the next.
   task automatic step(input logic [1:0] si, input logic cl);
      score_in = si;
      clear    = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic stepf(input logic [1:0] si);
      score_in_f = si;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_both(input int n);
      for (int i = 0; i < n; i++) begin
         step(2'b11, 1'b0);
         step(2'b00, 1'b0);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step(tbl[i].si, tbl[i].cl);
         chk($sformatf("row%0d_bcd", i), 32'(score_bcd), 32'(tbl[i].bcd));
         chk($sformatf("row%0d_strobe", i), 32'(point_strobe), 32'(tbl[i].st));
         chk($sformatf("row%0d_go", i), 32'(game_over), 32'(tbl[i].go));
         chk($sformatf("row%0d_win", i), 32'(winner_id), 32'(tbl[i].win));
      end
   endtask

   initial begin
      int nstrobe;

      // Three single-cycle pulses on player 0, 1 high / 2 low.
      tbl[0]  = mk(2'b01, 1'b0, 16'h0001, 2'b01, 1'b0, 1'b0);
      tbl[1]  = mk(2'b00, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0);
      tbl[2]  = mk(2'b00, 1'b0, 16'h0001, 2'b00, 1'b0, 1'b0);
      tbl[3]  = mk(2'b01, 1'b0, 16'h0002, 2'b01, 1'b0, 1'b0);
      tbl[4]  = mk(2'b00, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b0);
      tbl[5]  = mk(2'b00, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b0);
      tbl[6]  = mk(2'b01, 1'b0, 16'h0003, 2'b01, 1'b0, 1'b0);
      tbl[7]  = mk(2'b00, 1'b0, 16'h0003, 2'b00, 1'b0, 1'b0);
      tbl[8]  = mk(2'b00, 1'b0, 16'h0003, 2'b00, 1'b0, 1'b0);
      // Clear coincident with a player 1 rising edge, request then held across clear.
      tbl[9]  = mk(2'b00, 1'b0, 16'h0103, 2'b00, 1'b0, 1'b0);
      tbl[10] = mk(2'b10, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0);
      tbl[11] = mk(2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
      tbl[12] = mk(2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
      tbl[13] = mk(2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0);
      tbl[14] = mk(2'b10, 1'b0, 16'h0100, 2'b10, 1'b0, 1'b0);
      tbl[15] = mk(2'b00, 1'b0, 16'h0100, 2'b00, 1'b0, 1'b0);

      reset = 1'b1; clear = 1'b0; score_in = 2'b00;
      clear_f = 1'b0; score_in_f = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bcd", 32'(score_bcd), 32'h0);
      chk("rst_strobe", 32'(point_strobe), 32'h0);
      chk("rst_go", 32'(game_over), 32'h0);
      chk("rst_win", 32'(winner_id), 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      run_rows(0, 8);

      // Player 1 held high for 50 cycles counts once.
      nstrobe = 0;
      for (int i = 0; i < 50; i++) begin
         step(2'b10, 1'b0);
         if (i == 0)
            chk("hold_first_strobe", 32'(point_strobe), 32'h2);
         if (point_strobe[1])
            nstrobe++;
      end
      chk("hold_strobes", 32'(nstrobe), 32'd1);
      chk("hold_bcd", 32'(score_bcd), 32'h0103);

      run_rows(9, 15);

      // Simultaneous win at 11: lowest index wins, scores then freeze.
      step(2'b00, 1'b1);
      pulse_both(10);
      chk("pre_win_bcd", 32'(score_bcd), 32'h1010);
      chk("pre_win_go", 32'(game_over), 32'h0);
      step(2'b11, 1'b0);
      chk("win_bcd", 32'(score_bcd), 32'h1111);
      chk("win_strobe", 32'(point_strobe), 32'h3);
      chk("win_go", 32'(game_over), 32'h1);
      chk("win_id", 32'(winner_id), 32'h0);
      step(2'b00, 1'b0);
      step(2'b11, 1'b0);
      chk("frozen_bcd", 32'(score_bcd), 32'h1111);
      chk("frozen_strobe", 32'(point_strobe), 32'h0);
      chk("frozen_go", 32'(game_over), 32'h1);
      step(2'b00, 1'b1);
      chk("clr_go_bcd", 32'(score_bcd), 32'h0);
      chk("clr_go_go", 32'(game_over), 32'h0);
      chk("clr_go_win", 32'(winner_id), 32'h0);

      // Only player 1 reaches 11.
      pulse_both(10);
      step(2'b10, 1'b0);
      chk("win1_bcd", 32'(score_bcd), 32'h1110);
      chk("win1_go", 32'(game_over), 32'h1);
      chk("win1_id", 32'(winner_id), 32'h1);

      // Asynchronous reset mid-game at 0x07/0x05.
      step(2'b00, 1'b1);
      pulse_both(5);
      for (int i = 0; i < 2; i++) begin
         step(2'b01, 1'b0);
         step(2'b00, 1'b0);
      end
      chk("pre_rst_bcd", 32'(score_bcd), 32'h0507);
      #2 reset = 1'b1;
      #1;
      chk("arst_bcd", 32'(score_bcd), 32'h0);
      chk("arst_go", 32'(game_over), 32'h0);
      chk("arst_strobe", 32'(point_strobe), 32'h0);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      step(2'b01, 1'b0);
      chk("post_rst_bcd", 32'(score_bcd), 32'h0001);
      chk("post_rst_strobe", 32'(point_strobe), 32'h1);
      step(2'b00, 1'b0);

      // Free-play instance: BCD carry and saturation.
      for (int i = 0; i < 9; i++) begin
         stepf(2'b01);
         stepf(2'b00);
      end
      chk("free_9", 32'(score_bcd_f), 32'h0009);
      stepf(2'b01);
      chk("free_10", 32'(score_bcd_f), 32'h0010);
      stepf(2'b00);
      stepf(2'b01);
      chk("free_11_go", 32'(game_over_f), 32'h0);
      stepf(2'b00);
      for (int i = 0; i < 88; i++) begin
         stepf(2'b01);
         stepf(2'b00);
      end
      chk("free_99", 32'(score_bcd_f), 32'h0099);
      stepf(2'b01);
      chk("sat_bcd", 32'(score_bcd_f), 32'h0099);
      chk("sat_strobe", 32'(point_strobe_f), 32'h1);
      chk("sat_go", 32'(game_over_f), 32'h0);
      stepf(2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
